// File: rtl/opera_bus_fabric.sv
// Single-master Wishbone-classic address decoder and response fabric; hit ack at T+2 minimum, miss ack at T+1.
// No backpressure: one request in flight; misses and timeouts answer DEFAULT_DATA with m_err. BUS_FAULT_LOG_EN adds a fault log.
module opera_bus_fabric #(
  parameter int unsigned                 NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]    SLV_BASE       = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0]    SLV_MASK       = {NUM_SLAVES{32'h0}},
  parameter int unsigned                 TIMEOUT_CYCLES = 64,
  parameter logic [31:0]                 DEFAULT_DATA   = 32'hBADACCE5
) (
`ifdef BUS_FAULT_LOG_EN
  output logic [31:0]               fault_adr,
  output logic [7:0]                fault_cnt,
  output logic                      fault_irq,
`endif
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic [31:0]               m_adr,
  input  logic [31:0]               m_dat_w,
  input  logic [3:0]                m_sel,
  input  logic                      m_we,
  input  logic                      m_cyc,
  input  logic                      m_stb,
  output logic [31:0]               m_dat_r,
  output logic                      m_ack,
  output logic                      m_err,
  output logic [31:0]               s_adr,
  output logic [31:0]               s_dat_w,
  output logic [3:0]                s_sel,
  output logic                      s_we,
  output logic [NUM_SLAVES-1:0]     s_cyc,
  output logic [NUM_SLAVES-1:0]     s_stb,
  input  logic [NUM_SLAVES*32-1:0]  s_dat_r,
  input  logic [NUM_SLAVES-1:0]     s_ack
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          sel_idx;
  logic [TW-1:0]          tcnt;
  logic                   hit;
  logic [IW-1:0]          hit_idx;
  logic [NUM_SLAVES-1:0]  hit_onehot;
  logic                   start_hit, start_miss, abort, done_ok, done_to, err_ack;
  logic                   sel_ack;
  logic [31:0]            sel_dat;

  // Scan from the top down so the lowest-index match is the one left standing.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((m_adr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
    hit_onehot[hit_idx] = hit;
  end

  assign sel_ack = s_ack[sel_idx];
  assign sel_dat = s_dat_r[32*sel_idx +: 32];
  assign err_ack = start_miss | done_to;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_hit  = 1'b0;
    start_miss = 1'b0;
    abort      = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (m_cyc && m_stb) begin
          if (hit) begin
            start_hit = 1'b1;
            state_nxt = ACTIVE;
          end else begin
            start_miss = 1'b1;
            state_nxt  = RESP;
          end
        end
      end
      ACTIVE: begin
        // Abort beats ack; ack beats a timeout expiring in the same cycle.
        if (!m_cyc) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sel_ack) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt == TLIM)) begin
          done_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      s_adr   <= '0;
      s_dat_w <= '0;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_cyc   <= '0;
      s_stb   <= '0;
      sel_idx <= '0;
      tcnt    <= '0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_dat_r <= '0;
    end else begin
      m_ack <= start_miss | done_ok | done_to;
      m_err <= err_ack;
      if (start_hit || start_miss) begin
        s_adr   <= m_adr;
        s_dat_w <= m_dat_w;
        s_sel   <= m_sel;
        s_we    <= m_we;
      end
      if (start_hit) begin
        s_cyc   <= hit_onehot;
        s_stb   <= hit_onehot;
        sel_idx <= hit_idx;
      end else if (abort || done_ok || done_to) begin
        s_cyc <= '0;
        s_stb <= '0;
      end
      if (start_hit)            tcnt <= '0;
      else if (state == ACTIVE) tcnt <= tcnt + 1'b1;
      if (err_ack)      m_dat_r <= DEFAULT_DATA;
      else if (done_ok) m_dat_r <= s_we ? 32'h0 : sel_dat;
    end
  end

`ifdef BUS_FAULT_LOG_EN
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_adr <= '0;
      fault_cnt <= '0;
      fault_irq <= 1'b0;
    end else begin
      fault_irq <= err_ack;
      if (err_ack) begin
        fault_adr <= start_miss ? m_adr : s_adr;
        if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_opera_bus_fabric.sv
// Directed bench for opera_bus_fabric: per-cycle expectation tables built from the bus rules, checked on every falling edge.
`timescale 1ns/1ps
module tb_opera_bus_fabric;
  localparam int          NS    = 2;
  localparam int          TO    = 8;
  localparam logic [63:0] BASE  = {32'h03400000, 32'h03300000};
  localparam logic [63:0] MASK  = {32'hFFFF0000, 32'hFFFF0000};
  localparam logic [31:0] DEF   = 32'hBADACCE5;
  localparam int          DEPTH = 1024;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] m_adr, m_dat_w, m_dat_r;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb, m_ack, m_err;
  logic [31:0] s_adr, s_dat_w;
  logic [3:0]  s_sel;
  logic        s_we;
  logic [1:0]  s_cyc, s_stb, s_ack;
  logic [63:0] s_dat_r;
`ifdef BUS_FAULT_LOG_EN
  logic [31:0] fault_adr;
  logic [7:0]  fault_cnt;
  logic        fault_irq;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_t = 0;
  int n_err_exp = 0;

  bit [1:0]  e_stb  [DEPTH];
  bit        e_ack  [DEPTH];
  bit        e_err  [DEPTH];
  bit        e_dset [DEPTH];
  bit [31:0] e_dat  [DEPTH];
  bit [31:0] e_adr  [DEPTH];
  bit [31:0] e_wd   [DEPTH];
  bit [3:0]  e_sel  [DEPTH];
  bit        e_we   [DEPTH];

  logic [31:0] hold_dat = '0;
  int          obs_stb_cnt = 0;
  logic [1:0]  obs_stb = '0;
  logic [31:0] obs_wdat = '0;
  logic        obs_we = 1'b0;
  int          obs_ack_cyc = -1;
  logic [31:0] obs_ack_dat = '0;
  logic        obs_ack_err = 1'b0;

  opera_bus_fabric #(
    .NUM_SLAVES(NS), .SLV_BASE(BASE), .SLV_MASK(MASK),
    .TIMEOUT_CYCLES(TO), .DEFAULT_DATA(DEF)
  ) dut (
`ifdef BUS_FAULT_LOG_EN
    .fault_adr(fault_adr), .fault_cnt(fault_cnt), .fault_irq(fault_irq),
`endif
    .sys_clk(sys_clk), .reset_n(reset_n),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_we(m_we),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_dat_r(s_dat_r), .s_ack(s_ack)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if ((a & MASK[32*k +: 32]) == BASE[32*k +: 32]) return k;
    return -1;
  endfunction

  task automatic set_stb(input int c, input int k, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] sel, input logic we);
    e_stb[c] = 2'(1 << k);
    e_adr[c] = a;
    e_wd[c]  = wd;
    e_sel[c] = sel;
    e_we[c]  = we;
  endtask

  always @(negedge sys_clk) begin
    int c;
    c = cyc;
    if (!reset_n)       hold_dat = '0;
    else if (e_dset[c]) hold_dat = e_dat[c];
    chk("s_stb", 32'(s_stb), 32'(e_stb[c]));
    chk("s_cyc", 32'(s_cyc), 32'(e_stb[c]));
    chk("m_ack", 32'(m_ack), 32'(e_ack[c]));
    chk("m_err", 32'(m_err), 32'(e_err[c]));
    chk("m_dat_r", m_dat_r, hold_dat);
    if (e_stb[c] != 2'b00) begin
      chk("s_adr", s_adr, e_adr[c]);
      chk("s_dat_w", s_dat_w, e_wd[c]);
      chk("s_sel", 32'(s_sel), 32'(e_sel[c]));
      chk("s_we", 32'(s_we), 32'(e_we[c]));
    end
`ifdef BUS_FAULT_LOG_EN
    chk("fault_irq", 32'(fault_irq), 32'(e_ack[c] & e_err[c]));
`endif
    if (s_stb != 2'b00) begin
      obs_stb_cnt++;
      obs_stb  = s_stb;
      obs_wdat = s_dat_w;
      obs_we   = s_we;
    end
    if (m_ack === 1'b1) begin
      obs_ack_cyc = c;
      obs_ack_dat = m_dat_r;
      obs_ack_err = m_err;
    end
  end

  // delay: cycles after the first strobe cycle before the slave acks (<0: never).
  // junk: same offset rule, for a stray ack from the other slave.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sel, input logic we,
                        input int delay, input logic [31:0] rdat, input int junk);
    int t, k, last, r;
    logic err;
    logic [31:0] d;
    obs_stb_cnt = 0;
    step();
    t = cyc;
    last_t = t;
    m_adr = a; m_dat_w = wd; m_sel = sel; m_we = we; m_cyc = 1'b1; m_stb = 1'b1;
    k = decode(a);
    if (k < 0) begin
      last = t; r = t + 1; err = 1'b1; d = DEF;
    end else if (delay >= 0 && delay < TO) begin
      last = t + 1 + delay; r = last + 1; err = 1'b0; d = we ? 32'h0 : rdat;
    end else begin
      last = t + TO; r = last + 1; err = 1'b1; d = DEF;
    end
    if (k >= 0)
      for (int c = t + 1; c <= last; c++) set_stb(c, k, a, wd, sel, we);
    e_ack[r] = 1'b1; e_err[r] = err; e_dset[r] = 1'b1; e_dat[r] = d;
    for (int c = t + 1; c <= r; c++) begin
      step();
      s_ack = 2'b00;
      if (k >= 0 && delay >= 0 && c == t + 1 + delay) begin
        s_ack[k] = 1'b1;
        s_dat_r[32*k +: 32] = rdat;
      end
      if (k >= 0 && junk >= 0 && c == t + 1 + junk) begin
        s_ack[1-k] = 1'b1;
        s_dat_r[32*(1-k) +: 32] = 32'hDEADBEEF;
      end
    end
    step();
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = 2'b00;
    if (err) n_err_exp++;
`ifdef BUS_FAULT_LOG_EN
    chk("fault_cnt", 32'(fault_cnt), 32'(n_err_exp));
    if (err) chk("fault_adr", fault_adr, a);
`endif
  endtask

  task automatic do_abort(input logic [31:0] a, input int hold);
    int t, k;
    obs_stb_cnt = 0;
    step();
    t = cyc;
    m_adr = a; m_dat_w = 32'h0; m_sel = 4'hF; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    k = decode(a);
    for (int c = t + 1; c <= t + 1 + hold; c++) set_stb(c, k, a, 32'h0, 4'hF, 1'b0);
    for (int c = t + 1; c <= t + hold; c++) step();
    step();
    m_cyc = 1'b0; m_stb = 1'b0;
  endtask

  task automatic do_reset_mid();
    int t;
    step();
    t = cyc;
    m_adr = 32'h03300040; m_dat_w = 32'h0; m_sel = 4'hF; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    for (int c = t + 1; c <= t + 2; c++) set_stb(c, 0, m_adr, 32'h0, 4'hF, 1'b0);
    step(); step(); step();
    #2;
    reset_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    #1;
    chk("rst_mid_s_stb", 32'(s_stb), 32'h0);
    chk("rst_mid_s_cyc", 32'(s_cyc), 32'h0);
    chk("rst_mid_m_ack", 32'(m_ack), 32'h0);
    n_err_exp = 0;
    step(); step();
    @(negedge sys_clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_adr = '0; m_dat_w = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    s_ack = '0; s_dat_r = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_s_stb", 32'(s_stb), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc), 32'h0);
    chk("rst_m_ack", 32'(m_ack), 32'h0);
    chk("rst_m_err", 32'(m_err), 32'h0);
    chk("rst_m_dat_r", m_dat_r, 32'h0);
    chk("rst_s_adr", s_adr, 32'h0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    #1 reset_n = 1'b1;

    do_req(32'h03300010, 32'h0, 4'hF, 1'b0, 1, 32'h12345678, -1);
    chk("t1_lat", 32'(obs_ack_cyc - last_t), 32'd3);
    chk("t1_dat", obs_ack_dat, 32'h12345678);
    chk("t1_err", 32'(obs_ack_err), 32'h0);
    chk("t1_stb", 32'(obs_stb), 32'h1);

    do_req(32'h03400004, 32'hCAFEF00D, 4'hF, 1'b1, 1, 32'h0, -1);
    chk("t2_stb", 32'(obs_stb), 32'h2);
    chk("t2_wdat", obs_wdat, 32'hCAFEF00D);
    chk("t2_we", 32'(obs_we), 32'h1);
    chk("t2_lat", 32'(obs_ack_cyc - last_t), 32'd3);

    do_req(32'h00000000, 32'h0, 4'hF, 1'b0, 0, 32'h0, -1);
    chk("t3_lat", 32'(obs_ack_cyc - last_t), 32'd1);
    chk("t3_dat", obs_ack_dat, 32'hBADACCE5);
    chk("t3_err", 32'(obs_ack_err), 32'h1);
    chk("t3_nostb", 32'(obs_stb_cnt), 32'd0);

    do_req(32'h03300000, 32'h0, 4'hF, 1'b0, -1, 32'h0, -1);
    chk("t4_stb_len", 32'(obs_stb_cnt), 32'd8);
    chk("t4_lat", 32'(obs_ack_cyc - last_t), 32'd9);
    chk("t4_dat", obs_ack_dat, 32'hBADACCE5);
    chk("t4_err", 32'(obs_ack_err), 32'h1);

    do_req(32'h03300020, 32'h0, 4'h3, 1'b0, 3, 32'hA5A5A5A5, 1);
    chk("t5_lat", 32'(obs_ack_cyc - last_t), 32'd5);
    chk("t5_dat", obs_ack_dat, 32'hA5A5A5A5);

    obs_ack_cyc = -1;
    do_abort(32'h03300030, 2);
    step();
    chk("t5_abort_stb_len", 32'(obs_stb_cnt), 32'd3);
    chk("t5_abort_noack", 32'(obs_ack_cyc), 32'hFFFFFFFF);

    do_req(32'h03400008, 32'h0, 4'h1, 1'b0, 0, 32'h0BADF00D, -1);
    chk("zw_lat", 32'(obs_ack_cyc - last_t), 32'd2);
    chk("zw_dat", obs_ack_dat, 32'h0BADF00D);

    do_req(32'h0330FFFC, 32'h0, 4'hF, 1'b0, 7, 32'h13579BDF, -1);
    chk("edge_ack_err", 32'(obs_ack_err), 32'h0);
    chk("edge_ack_dat", obs_ack_dat, 32'h13579BDF);

    do_req(32'h03400010, 32'h0, 4'hF, 1'b0, 8, 32'h2468ACE0, -1);
    chk("late_ack_err", 32'(obs_ack_err), 32'h1);
    chk("late_ack_dat", obs_ack_dat, 32'hBADACCE5);

    do_reset_mid();
`ifdef BUS_FAULT_LOG_EN
    chk("rst_fault_cnt", 32'(fault_cnt), 32'h0);
`endif
    do_req(32'h03400000, 32'h0, 4'hF, 1'b0, 2, 32'h55AA55AA, -1);
    chk("t6_lat", 32'(obs_ack_cyc - last_t), 32'd4);
    chk("t6_dat", obs_ack_dat, 32'h55AA55AA);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
